fan_pwm_ramp: RTL and testbench

Parametrised fan PWM generator: the next generation of the fixed four-level fan speed block.
- Takes an arbitrary duty target (in clk_us ticks) instead of a 2-bit level.
- Slew-limits duty changes once per PWM period.
- Applies a full-on kickstart when the fan starts from standstill.
- Sits between the music-analysis/level logic and the fan driver pin. Period boundaries are exported so other logic can align to them.

---
 rtl/fan_pwm_ramp.sv | 188 ++++++++++++++++++
 tb/tb_fan_pwm_ramp.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fan_pwm_ramp.sv
// Fan PWM generator with per-period slew limiting and a full-on kickstart from standstill.
// Period boundaries are exported on period_start so neighbouring logic can align to them.
module fan_pwm_ramp #(
    parameter int PERIOD       = 2000,
    parameter int CNT_W        = 11,
    parameter int DUTY_W       = 11,
    parameter int STEP         = 100,
    parameter int KICK_PERIODS = 4,
    parameter int INVERT       = 1
) (
    input  logic              clk_us,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_target,
    output logic              speed_ctl,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              period_start,
    output logic              at_target,
    output logic              kicking
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DUTY_W-1:0] PERIOD_D  = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
    localparam logic [3:0]        KICK_INIT = (KICK_PERIODS > 0) ? 4'(KICK_PERIODS - 1) : 4'd0;
    localparam logic              INV_L     = (INVERT != 0) ? 1'b1 : 1'b0;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [DUTY_W-1:0] duty_cur_r;
    logic [DUTY_W-1:0] duty_nxt_s;
    logic [3:0]        kick_cnt_r;
    logic [3:0]        kick_nxt_s;
    logic [DUTY_W-1:0] eff_s;
    logic [DUTY_W-1:0] duty_eff_nxt_s;
    logic              boundary_s;
    logic              on_nxt_s;
    logic              speed_ctl_r;
    logic              period_start_r;
    logic              kicking_r;
    logic              at_target_s;

    // Largest permitted duty move toward the target this period.
    function automatic logic [DUTY_W-1:0] step_lim(input logic [DUTY_W-1:0] diff);
        if (diff < STEP_D) begin
            step_lim = diff;
        end else begin
            step_lim = STEP_D;
        end
    endfunction

    // Effective target: clamped request, forced to zero when disabled.
    always_comb begin
        eff_s = DUTY_ZERO;
        if (!enable) begin
            eff_s = DUTY_ZERO;
        end else if (duty_target > PERIOD_D) begin
            eff_s = PERIOD_D;
        end else begin
            eff_s = duty_target;
        end
    end

    assign boundary_s = (cnt_r == CNT_LAST);

    // Next phase count, state, duty and kick count; only the boundary moves state.
    always_comb begin
        state_nxt_s = state_r;
        duty_nxt_s  = duty_cur_r;
        kick_nxt_s  = kick_cnt_r;
        if (boundary_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
        if (boundary_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (eff_s == DUTY_ZERO) begin
                        state_nxt_s = ST_IDLE;
                    end else if (KICK_PERIODS > 0) begin
                        state_nxt_s = ST_KICK;
                        kick_nxt_s  = KICK_INIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                        duty_nxt_s  = step_lim(eff_s);
                    end
                end
                ST_KICK: begin
                    if (eff_s == DUTY_ZERO) begin
                        state_nxt_s = ST_IDLE;
                        kick_nxt_s  = 4'd0;
                    end else if (kick_cnt_r == 4'd0) begin
                        state_nxt_s = ST_RUN;
                        duty_nxt_s  = step_lim(eff_s);
                    end else begin
                        kick_nxt_s  = kick_cnt_r - 4'd1;
                    end
                end
                ST_RUN: begin
                    // Differences are taken only in the direction known to be positive.
                    if (duty_cur_r < eff_s) begin
                        duty_nxt_s = duty_cur_r + step_lim(eff_s - duty_cur_r);
                    end else if (duty_cur_r > eff_s) begin
                        duty_nxt_s = duty_cur_r - step_lim(duty_cur_r - eff_s);
                    end else begin
                        duty_nxt_s = duty_cur_r;
                    end
                    if ((duty_nxt_s == DUTY_ZERO) && (eff_s == DUTY_ZERO)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    duty_nxt_s  = DUTY_ZERO;
                    kick_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Duty that will be applied in the next cycle, used to pre-register the PWM pin.
    always_comb begin
        duty_eff_nxt_s = DUTY_ZERO;
        case (state_nxt_s)
            ST_IDLE: duty_eff_nxt_s = DUTY_ZERO;
            ST_KICK: duty_eff_nxt_s = PERIOD_D;
            ST_RUN:  duty_eff_nxt_s = duty_nxt_s;
            default: duty_eff_nxt_s = DUTY_ZERO;
        endcase
        on_nxt_s = (32'(cnt_nxt_s) < 32'(duty_eff_nxt_s));
    end

    // State registers and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk_us) begin
        if (!rst_n) begin
            cnt_r          <= CNT_ZERO;
            state_r        <= ST_IDLE;
            duty_cur_r     <= DUTY_ZERO;
            kick_cnt_r     <= 4'd0;
            speed_ctl_r    <= INV_L;
            period_start_r <= 1'b1;
            kicking_r      <= 1'b0;
        end else begin
            cnt_r          <= cnt_nxt_s;
            state_r        <= state_nxt_s;
            duty_cur_r     <= duty_nxt_s;
            kick_cnt_r     <= kick_nxt_s;
            speed_ctl_r    <= on_nxt_s ^ INV_L;
            period_start_r <= (cnt_nxt_s == CNT_ZERO);
            kicking_r      <= (state_nxt_s == ST_KICK);
        end
    end

    // Target-reached flag tracks the live effective target.
    always_comb begin
        at_target_s = 1'b0;
        if (state_r == ST_RUN) begin
            at_target_s = (duty_cur_r == eff_s);
        end else if (state_r == ST_IDLE) begin
            at_target_s = (eff_s == DUTY_ZERO);
        end else begin
            at_target_s = 1'b0;
        end
    end

    assign speed_ctl    = speed_ctl_r;
    assign duty_cur     = duty_cur_r;
    assign period_start = period_start_r;
    assign kicking      = kicking_r;
    assign at_target    = at_target_s;

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Directed bench for fan_pwm_ramp: PERIOD=10, STEP=3, two kick periods, both output polarities.
module tb_fan_pwm_ramp;

    logic       clk_us = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] duty_target;
    logic       speed_ctl;
    logic [3:0] duty_cur;
    logic       period_start;
    logic       at_target;
    logic       kicking;
    logic       speed_ctl_n0;
    logic [3:0] duty_cur_n0;
    logic       period_start_n0;
    logic       at_target_n0;
    logic       kicking_n0;

    int checks = 0;
    int errors = 0;

    fan_pwm_ramp #(.PERIOD(10), .CNT_W(4), .DUTY_W(4), .STEP(3), .KICK_PERIODS(2), .INVERT(1)) dut (
        .clk_us(clk_us), .rst_n(rst_n), .enable(enable), .duty_target(duty_target),
        .speed_ctl(speed_ctl), .duty_cur(duty_cur), .period_start(period_start),
        .at_target(at_target), .kicking(kicking)
    );

    fan_pwm_ramp #(.PERIOD(10), .CNT_W(4), .DUTY_W(4), .STEP(3), .KICK_PERIODS(2), .INVERT(0)) dut_n0 (
        .clk_us(clk_us), .rst_n(rst_n), .enable(enable), .duty_target(duty_target),
        .speed_ctl(speed_ctl_n0), .duty_cur(duty_cur_n0), .period_start(period_start_n0),
        .at_target(at_target_n0), .kicking(kicking_n0)
    );

    always #5 clk_us = ~clk_us;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_us);
        #1;
    endtask

    // One full PWM period from the cnt==0 cycle; optional target change after sample mid_idx.
    task automatic run_period(input string tag, input int exp_on, input int exp_kick,
                              input int exp_duty, input int exp_at,
                              input int mid_idx, input int mid_tgt);
        int on_n = 0;
        int shape_bad = 0;
        int inv_bad = 0;
        int ps_bad = 0;
        int kick_bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 0) begin
                check_eq({tag, ".duty"}, int'(duty_cur), exp_duty);
                check_eq({tag, ".at"}, int'(at_target), exp_at);
            end
            if (speed_ctl != ((i < exp_on) ? 1'b0 : 1'b1)) shape_bad++;
            if (speed_ctl == 1'b0) on_n++;
            if (speed_ctl_n0 != ~speed_ctl) inv_bad++;
            if (period_start != (i == 0)) ps_bad++;
            if (int'(kicking) != exp_kick) kick_bad++;
            if (i == mid_idx) duty_target = 4'(mid_tgt);
            tick();
        end
        check_eq({tag, ".on"}, on_n, exp_on);
        check_eq({tag, ".shape"}, shape_bad, 0);
        check_eq({tag, ".inv0"}, inv_bad, 0);
        check_eq({tag, ".pstart"}, ps_bad, 0);
        check_eq({tag, ".kick"}, kick_bad, 0);
    endtask

    initial begin
        int pk_bad;
        rst_n       = 1'b0;
        enable      = 1'b1;
        duty_target = 4'd5;
        repeat (3) tick();
        #1;
        check_eq("rst.speed", int'(speed_ctl), 1);
        check_eq("rst.speed_n0", int'(speed_ctl_n0), 0);
        check_eq("rst.duty", int'(duty_cur), 0);
        check_eq("rst.kick", int'(kicking), 0);
        check_eq("rst.pstart", int'(period_start), 1);
        check_eq("rst.at", int'(at_target), 0);
        rst_n       = 1'b1;
        duty_target = 4'd7;

        run_period("idle0", 0, 0, 0, 0, -1, 0);
        run_period("kick1", 10, 1, 0, 0, -1, 0);
        run_period("kick2", 10, 1, 0, 0, -1, 0);
        run_period("up3", 3, 0, 3, 0, -1, 0);
        run_period("up6", 6, 0, 6, 0, -1, 0);
        run_period("up7", 7, 0, 7, 1, -1, 0);

        enable = 1'b0;
        run_period("dn7", 7, 0, 7, 0, -1, 0);
        run_period("dn4", 4, 0, 4, 0, -1, 0);
        run_period("dn1", 1, 0, 1, 0, -1, 0);
        run_period("off", 0, 0, 0, 1, -1, 0);

        enable = 1'b1;
        run_period("re_idle", 0, 0, 0, 0, -1, 0);
        run_period("re_kick1", 10, 1, 0, 0, -1, 0);
        run_period("re_kick2", 10, 1, 0, 0, -1, 0);
        run_period("re_up3", 3, 0, 3, 0, -1, 0);
        run_period("re_up6", 6, 0, 6, 0, -1, 0);
        run_period("re_up7", 7, 0, 7, 1, -1, 0);

        run_period("mid7", 7, 0, 7, 1, 4, 1);
        duty_target = 4'd9;
        run_period("rev4", 4, 0, 4, 0, -1, 0);
        run_period("rev7", 7, 0, 7, 0, -1, 0);
        run_period("rev9", 9, 0, 9, 1, -1, 0);

        duty_target = 4'd15;
        run_period("clamp9", 9, 0, 9, 0, -1, 0);
        run_period("clamp10", 10, 0, 10, 1, -1, 0);
        run_period("clamp10b", 10, 0, 10, 1, -1, 0);

        duty_target = 4'd7;
        rst_n       = 1'b0;
        tick();
        rst_n = 1'b1;
        run_period("rk_idle", 0, 0, 0, 0, -1, 0);
        pk_bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (speed_ctl != 1'b0 || kicking != 1'b1) pk_bad++;
            if (i < 5) tick();
        end
        check_eq("rk_partial", pk_bad, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rk_rst.speed", int'(speed_ctl), 1);
        check_eq("rk_rst.kick", int'(kicking), 0);
        check_eq("rk_rst.pstart", int'(period_start), 1);
        check_eq("rk_rst.duty", int'(duty_cur), 0);
        run_period("rk_idle2", 0, 0, 0, 0, -1, 0);
        run_period("rk_kick1", 10, 1, 0, 0, -1, 0);
        run_period("rk_kick2", 10, 1, 0, 0, -1, 0);
        run_period("rk_up3", 3, 0, 3, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
